// File: rtl/pll_seq_pkg.sv
// Shared types and default widths for the PLL configuration sweep sequencer.
package pll_seq_pkg;

    localparam int AW_DEF  = 8;
    localparam int CBW_DEF = 16;

    // state       | meaning
    // S_IDLE      | waiting for START
    // S_LOAD      | new address on PLL_ADDR, settling one cycle
    // S_PULSE     | PLL_CHG strobe to pll_ctrl
    // S_BLANK     | DRP reprogram time, lock ignored
    // S_WAIT_LOCK | waiting for synchronized lock, bounded by LOCK_TO
    // S_DWELL     | holding a locked step for DWELL cycles
    // S_NEXT      | compute next address or end the sweep
    // S_FINISH    | DONE pulse, back to idle
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_PULSE     = 3'd2,
        S_BLANK     = 3'd3,
        S_WAIT_LOCK = 3'd4,
        S_DWELL     = 3'd5,
        S_NEXT      = 3'd6,
        S_FINISH    = 3'd7
    } seq_state_t;

endpackage

// File: rtl/pll_sweep_seq_if.sv
// Control/status bundle between a sweep requester and pll_sweep_seq.
interface pll_sweep_seq_if #(
    parameter int AW  = 8,
    parameter int CBW = 16
);
    logic           start_i;
    logic           stop_i;
    logic [AW-1:0]  addr_first_i;
    logic [AW-1:0]  addr_last_i;
    logic [AW-1:0]  addr_step_i;
    logic [CBW-1:0] dwell_i;
    logic           lock_async_i;
    logic [AW-1:0]  pll_addr_o;
    logic           pll_chg_o;
    logic           busy_o;
    logic           step_done_o;
    logic           done_o;
    logic           err_o;
    logic [AW-1:0]  cur_step_o;

    modport master (
        output start_i, stop_i, addr_first_i, addr_last_i, addr_step_i, dwell_i, lock_async_i,
        input  pll_addr_o, pll_chg_o, busy_o, step_done_o, done_o, err_o, cur_step_o
    );

    modport slave (
        input  start_i, stop_i, addr_first_i, addr_last_i, addr_step_i, dwell_i, lock_async_i,
        output pll_addr_o, pll_chg_o, busy_o, step_done_o, done_o, err_o, cur_step_o
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, async active-low reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/pll_sweep_seq.sv
// Steps pll_ctrl through a range of DRP configuration addresses, waiting for lock
// and dwelling on each step; reports per-step completion, end of sweep and lock timeouts.
module pll_sweep_seq
    import pll_seq_pkg::*;
#(
    parameter int            AW       = AW_DEF,
    parameter int            CBW      = CBW_DEF,
    parameter int            BLANK    = 255,
    parameter int            LOCK_TO  = 65535,
    parameter logic [AW-1:0] ADDR_RST = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    pll_sweep_seq_if.slave   bus
);
    // A state lasting N cycles is loaded with N-1 and leaves on terminal count.
    localparam logic [CBW-1:0] BLANK_LD = CBW'(BLANK - 1);
    localparam logic [CBW-1:0] TO_LD    = CBW'(LOCK_TO - 1);

    seq_state_t     state_q, state_d;
    logic [CBW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [AW-1:0]  last_q, last_d;
    logic [AW-1:0]  step_q, step_d;
    logic [CBW-1:0] dwell_q, dwell_d;
    logic [AW-1:0]  cur_q, cur_d;
    logic           abort_q, abort_d;
    logic           chg_q, chg_d;
    logic           busy_q, busy_d;
    logic           sd_q, sd_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           lock_s;
    logic           cnt_tc;
    logic [AW:0]    nxt;
    logic           sweep_end;
    logic [CBW-1:0] dwell_ld;

    sync_2ff u_lock_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (bus.lock_async_i),
        .q_o     (lock_s)
    );

    assign cnt_tc    = (cnt_q == '0);
    assign nxt       = {1'b0, addr_q} + {1'b0, step_q};
    assign sweep_end = nxt[AW] || (nxt[AW-1:0] > last_q);
    assign dwell_ld  = (dwell_q == '0) ? '0 : dwell_q - CBW'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= ADDR_RST;
            last_q  <= '0;
            step_q  <= '0;
            dwell_q <= '0;
            cur_q   <= '0;
            abort_q <= 1'b0;
            chg_q   <= 1'b0;
            busy_q  <= 1'b0;
            sd_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
            cur_q   <= cur_d;
            abort_q <= abort_d;
            chg_q   <= chg_d;
            busy_q  <= busy_d;
            sd_q    <= sd_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (bus.start_i) state_d = S_LOAD;
            S_LOAD:      state_d = bus.stop_i ? S_FINISH : S_PULSE;
            S_PULSE:     state_d = S_BLANK;
            S_BLANK:     if (cnt_tc) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                // Lock takes priority over a timeout expiring in the same cycle.
                if (lock_s) begin
                    state_d = (abort_q || bus.stop_i) ? S_FINISH : S_DWELL;
                end else if (cnt_tc) begin
                    state_d = S_FINISH;
                end
            end
            S_DWELL: begin
                if (bus.stop_i || !lock_s) begin
                    state_d = S_FINISH;
                end else if (cnt_tc) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT:      state_d = (bus.stop_i || sweep_end) ? S_FINISH : S_LOAD;
            S_FINISH:    state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        last_d  = last_q;
        step_d  = step_q;
        dwell_d = dwell_q;
        cur_d   = cur_q;
        abort_d = abort_q;
        err_d   = err_q;

        if (state_q == S_IDLE && bus.start_i) begin
            addr_d  = bus.addr_first_i;
            last_d  = bus.addr_last_i;
            step_d  = (bus.addr_step_i == '0) ? AW'(1) : bus.addr_step_i;
            dwell_d = bus.dwell_i;
            cur_d   = '0;
            err_d   = 1'b0;
        end

        // Aborts requested while the PLL is reprogramming wait for WAIT_LOCK to resolve.
        if ((state_q == S_PULSE || state_q == S_BLANK || state_q == S_WAIT_LOCK) && bus.stop_i) begin
            abort_d = 1'b1;
        end
        if (state_q == S_FINISH) begin
            abort_d = 1'b0;
        end

        if ((state_q == S_WAIT_LOCK && !lock_s && cnt_tc) ||
            (state_q == S_DWELL && !bus.stop_i && !lock_s)) begin
            err_d = 1'b1;
        end

        if (state_q == S_NEXT && state_d == S_LOAD) begin
            addr_d = nxt[AW-1:0];
            cur_d  = cur_q + AW'(1);
        end

        if ((state_q == S_BLANK || state_q == S_WAIT_LOCK || state_q == S_DWELL) && !cnt_tc) begin
            cnt_d = cnt_q - CBW'(1);
        end
        if (state_d != state_q) begin
            unique case (state_d)
                S_BLANK:     cnt_d = BLANK_LD;
                S_WAIT_LOCK: cnt_d = TO_LD;
                S_DWELL:     cnt_d = dwell_ld;
                default:     ;
            endcase
        end

        chg_d  = (state_d == S_PULSE);
        busy_d = (state_d != S_IDLE) && (state_d != S_FINISH);
        sd_d   = (state_q == S_DWELL) && (state_d == S_NEXT);
        done_d = (state_d == S_FINISH);
    end

    assign bus.pll_addr_o  = addr_q;
    assign bus.pll_chg_o   = chg_q;
    assign bus.busy_o      = busy_q;
    assign bus.step_done_o = sd_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.cur_step_o  = cur_q;
endmodule

// File: tb/tb_pll_sweep_seq.sv
// Scoreboard bench for pll_sweep_seq: expected CHG/STEP_DONE/DONE events are queued
// by the stimulus and popped by an independent monitor.
module tb_pll_sweep_seq;
    localparam int AW       = 8;
    localparam int CBW      = 16;
    localparam int BLANK    = 4;
    localparam int LOCK_TO  = 20;
    localparam int LOCK_DLY = 10;
    localparam int BUDGET   = 3000;

    typedef enum int {EV_CHG = 0, EV_SD = 1, EV_DONE = 2} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       val;
        int       err;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pll_sweep_seq_if #(.AW(AW), .CBW(CBW)) sif();

    pll_sweep_seq #(
        .AW(AW), .CBW(CBW), .BLANK(BLANK), .LOCK_TO(LOCK_TO), .ADDR_RST(8'h00)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (sif)
    );

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  chg_cyc = 0;
    int  done_cyc = 0;
    int  done_cnt = 0;
    bit  lock_en = 1'b1;
    bit  drop_req = 1'b0;
    int  lock_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input int v, input int e);
        ev_t x;
        x.kind = k;
        x.val  = v;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    // Reference: addresses first, first+s, ... up to last, never past 2**AW-1, at least one step.
    task automatic push_sweep(input int first, input int last, input int step,
                              output int fin_addr, output int fin_idx);
        int s, a, i;
        s = (step == 0) ? 1 : step;
        a = first;
        i = 0;
        forever begin
            push_ev(EV_CHG, a, 0);
            push_ev(EV_SD, i, 0);
            if (a + s > last || a + s > 255) break;
            a = a + s;
            i++;
        end
        push_ev(EV_DONE, i, 0);
        fin_addr = a;
        fin_idx  = i;
    endtask

    task automatic pop_check(input ev_kind_t k, input int v, input int e);
        ev_t x;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d value %0d, expected none", int'(k), v);
        end else begin
            x = exp_q.pop_front();
            check("event_kind", int'(k), int'(x.kind));
            check("event_value", v, x.val);
            if (k == EV_DONE) check("done_err", e, x.err);
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (sif.pll_chg_o) begin
                    chg_cyc = cyc;
                    pop_check(EV_CHG, int'(sif.pll_addr_o), 0);
                end
                if (sif.step_done_o) pop_check(EV_SD, int'(sif.cur_step_o), 0);
                if (sif.done_o) begin
                    done_cyc = cyc;
                    pop_check(EV_DONE, int'(sif.cur_step_o), int'(sif.err_o));
                    check("busy_at_done", int'(sif.busy_o), 0);
                    done_cnt++;
                end
            end
        end
    end

    // Lock model: drops on PLL_CHG, returns LOCK_DLY cycles later when enabled.
    initial begin
        sif.lock_async_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                lock_cnt = 0;
                sif.lock_async_i = 1'b0;
            end else if (drop_req) begin
                sif.lock_async_i = 1'b0;
            end else if (sif.pll_chg_o) begin
                sif.lock_async_i = 1'b0;
                lock_cnt = LOCK_DLY;
            end else if (lock_cnt > 0) begin
                lock_cnt--;
                if (lock_cnt == 0 && lock_en) sif.lock_async_i = 1'b1;
            end
        end
    end

    task automatic start_sweep(input int first, input int last, input int step, input int dwell);
        @(negedge clk);
        sif.addr_first_i = AW'(first);
        sif.addr_last_i  = AW'(last);
        sif.addr_step_i  = AW'(step);
        sif.dwell_i      = CBW'(dwell);
        sif.start_i      = 1'b1;
        @(negedge clk);
        sif.start_i      = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n0;
        n0 = done_cnt;
        for (int i = 0; i < BUDGET && done_cnt == n0; i++) @(negedge clk);
        checks++;
        if (done_cnt == n0) begin
            errors++;
            $display("FAIL %s_timeout: got no DONE, expected DONE within %0d cycles", name, BUDGET);
        end
        check({name, "_queue_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_chg(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk);
            seen = sif.pll_chg_o;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_chg_timeout: got no PLL_CHG, expected one", name);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_pll_addr"}, int'(sif.pll_addr_o), 0);
        check({name, "_pll_chg"}, int'(sif.pll_chg_o), 0);
        check({name, "_busy"}, int'(sif.busy_o), 0);
        check({name, "_step_done"}, int'(sif.step_done_o), 0);
        check({name, "_done"}, int'(sif.done_o), 0);
        check({name, "_err"}, int'(sif.err_o), 0);
        check({name, "_cur_step"}, int'(sif.cur_step_o), 0);
    endtask

    initial begin
        int fa, fi, first, last, step, dwell;
        sif.start_i = 1'b0;
        sif.stop_i = 1'b0;
        sif.addr_first_i = '0;
        sif.addr_last_i = '0;
        sif.addr_step_i = '0;
        sif.dwell_i = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: normal sweep
        push_sweep(10, 14, 2, fa, fi);
        start_sweep(10, 14, 2, 5);
        check("t1_busy", int'(sif.busy_o), 1);
        wait_done("t1");
        check("t1_pll_addr", int'(sif.pll_addr_o), fa);
        check("t1_cur_step", int'(sif.cur_step_o), 2);
        check("t1_err", int'(sif.err_o), 0);

        // 2: top-of-range, step 0 treated as 1
        push_sweep(8'hFE, 8'hFF, 0, fa, fi);
        start_sweep(8'hFE, 8'hFF, 0, 1);
        wait_done("t2");
        check("t2_pll_addr", int'(sif.pll_addr_o), 8'hFF);

        // 3: lock timeout, then START clears ERR
        lock_en = 1'b0;
        push_ev(EV_CHG, 8'h30, 0);
        push_ev(EV_DONE, 0, 1);
        start_sweep(8'h30, 8'h40, 1, 3);
        wait_done("t3");
        check("t3_timeout_latency", done_cyc - chg_cyc, BLANK + LOCK_TO + 1);
        check("t3_err", int'(sif.err_o), 1);
        lock_en = 1'b1;
        push_sweep(5, 5, 1, fa, fi);
        start_sweep(5, 5, 1, 0);
        check("t3_err_cleared", int'(sif.err_o), 0);
        wait_done("t3b");

        // 4: STOP during BLANK
        push_ev(EV_CHG, 10, 0);
        push_ev(EV_DONE, 0, 0);
        start_sweep(10, 14, 2, 5);
        wait_chg("t4");
        @(negedge clk);
        sif.stop_i = 1'b1;
        @(negedge clk);
        sif.stop_i = 1'b0;
        wait_done("t4");
        check("t4_done_latency", done_cyc - chg_cyc, LOCK_DLY + 2 + 1);
        check("t4_pll_addr", int'(sif.pll_addr_o), 10);
        check("t4_err", int'(sif.err_o), 0);

        // 5: lock lost 20 cycles into a 50-cycle dwell
        push_ev(EV_CHG, 8'h20, 0);
        push_ev(EV_DONE, 0, 1);
        start_sweep(8'h20, 8'h22, 1, 50);
        wait_chg("t5");
        repeat (LOCK_DLY + 3 + 20) @(negedge clk);
        drop_req = 1'b1;
        wait_done("t5");
        drop_req = 1'b0;
        check("t5_err", int'(sif.err_o), 1);
        check("t5_busy", int'(sif.busy_o), 0);

        // 6a: START while busy has no effect
        push_sweep(40, 60, 5, fa, fi);
        start_sweep(40, 60, 5, 2);
        wait_chg("t6a");
        start_sweep(100, 200, 7, 9);
        wait_done("t6a");
        check("t6a_pll_addr", int'(sif.pll_addr_o), fa);
        check("t6a_cur_step", int'(sif.cur_step_o), fi);

        // Randomized sweeps, including FIRST > LAST
        for (int n = 0; n < 10; n++) begin
            first = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0 && first > 0) last = int'($urandom_range(0, first - 1));
            else last = first + int'($urandom_range(0, 24));
            if (last > 255) last = 255;
            step  = int'($urandom_range(0, 6));
            dwell = int'($urandom_range(0, 6));
            push_sweep(first, last, step, fa, fi);
            start_sweep(first, last, step, dwell);
            wait_done("rnd");
            check("rnd_pll_addr", int'(sif.pll_addr_o), fa);
            check("rnd_cur_step", int'(sif.cur_step_o), fi);
        end

        // 6b: async reset mid-sweep
        push_sweep(70, 90, 10, fa, fi);
        start_sweep(70, 90, 10, 4);
        wait_chg("t6b");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t6b_rst");
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_reset_outputs("t6b_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
